gray_ptr_sync_mc: RTL

//  Parametrised successor to the 2-flop read-to-write pointer synchroniser. Carries NUM_CH Gray-coded

---
 rtl/gray_ptr_sync_mc_pkg.sv | 52 +++++
 rtl/gray_ptr_sync_mc_if.sv | 24 ++
 rtl/gray_ptr_sync_mc_ch.sv | 95 +++++++++
 rtl/gray_ptr_sync_mc.sv | 63 ++++++
 4 files changed

// File: rtl/gray_ptr_sync_mc_pkg.sv
// Shared helpers for the multi-channel Gray pointer synchroniser: Gray/binary
// conversion, population count and the legal synchroniser depth range.
package gray_ptr_sync_pkg;

  localparam int MIN_STAGES = 2;
  localparam int MAX_STAGES = 4;
  localparam int MIN_CH     = 1;
  localparam int MAX_CH     = 8;

  // Bits at or above 'width' are returned as zero, so callers can slice the low bits.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int width);
    logic [31:0] b;
    logic        acc;
    b   = 32'd0;
    acc = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (i < width) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end else begin
        b[i] = 1'b0;
      end
    end
    return b;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b, input int width);
    logic [31:0] mask;
    logic [31:0] masked;
    if (width >= 32) begin
      mask = 32'hFFFF_FFFF;
    end else begin
      mask = (32'd1 << width) - 32'd1;
    end
    masked = b & mask;
    return masked ^ (masked >> 1);
  endfunction

  function automatic int popcount(input logic [31:0] v, input int width);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if ((i < width) && v[i]) begin
        cnt++;
      end else begin
        cnt = cnt;
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gray_ptr_sync_mc_if.sv
// Pointer bundle between the read-pointer source, the synchroniser and the
// write-side flag logic. Channel c occupies bits [c*(PTR_WIDTH+1) +: PTR_WIDTH+1].
interface gray_ptr_sync_mc_if #(
  parameter int PTR_WIDTH = 9,
  parameter int NUM_CH    = 1
);
  logic [NUM_CH*(PTR_WIDTH+1)-1:0] rptr_gray;
  logic                            err_clr;
  logic [NUM_CH*(PTR_WIDTH+1)-1:0] rptr_sync;
  logic [NUM_CH*(PTR_WIDTH+1)-1:0] rptr_bin;
  logic [NUM_CH*(PTR_WIDTH+1)-1:0] rptr_delta;
  logic [NUM_CH-1:0]               rptr_upd;
  logic [NUM_CH-1:0]               gray_err;

  modport master (
    output rptr_gray, err_clr,
    input  rptr_sync, rptr_bin, rptr_delta, rptr_upd, gray_err
  );

  modport slave (
    input  rptr_gray, err_clr,
    output rptr_sync, rptr_bin, rptr_delta, rptr_upd, gray_err
  );
endinterface

// File: rtl/gray_ptr_sync_mc_ch.sv
// One pointer channel: STAGES-deep synchroniser, registered binary, advance
// delta and update pulse. Gray integrity checker built when GRAY_PTR_SYNC_CHK_EN is defined.
module gray_ptr_sync_ch
  import gray_ptr_sync_pkg::*;
#(
  parameter int PTR_WIDTH = 9,
  parameter int STAGES    = 2
) (
  input  logic               wclk,
  input  logic               w_rst,
  input  logic [PTR_WIDTH:0] rptr_gray,
  input  logic               err_clr,
  output logic [PTR_WIDTH:0] rptr_sync,
  output logic [PTR_WIDTH:0] rptr_bin,
  output logic [PTR_WIDTH:0] rptr_delta,
  output logic               rptr_upd,
  output logic               gray_err
);

  localparam int W = PTR_WIDTH + 1;

  logic [PTR_WIDTH:0] stage_q [STAGES];
  logic [PTR_WIDTH:0] stage_d [STAGES];
  logic [PTR_WIDTH:0] bin_q, bin_d;
  logic [PTR_WIDTH:0] delta_q, delta_d;
  logic               upd_q, upd_d;
  logic [31:0]        bin_ext_s;

  // Next state of the synchroniser chain, binary pointer, delta and pulse.
  always_comb begin
    stage_d[0] = rptr_gray;
    for (int k = 1; k < STAGES; k++) begin
      stage_d[k] = stage_q[k-1];
    end
    bin_ext_s = gray2bin(32'(stage_q[STAGES-1]), W);
    bin_d     = bin_ext_s[PTR_WIDTH:0];
    delta_d   = bin_d - bin_q;
    upd_d     = (delta_d != {W{1'b0}});
  end

  // Data-path registers; reset discards anything still in the chain.
  always_ff @(posedge wclk) begin
    if (w_rst) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= {W{1'b0}};
      end
      bin_q   <= {W{1'b0}};
      delta_q <= {W{1'b0}};
      upd_q   <= 1'b0;
    end else begin
      stage_q <= stage_d;
      bin_q   <= bin_d;
      delta_q <= delta_d;
      upd_q   <= upd_d;
    end
  end

  assign rptr_sync  = stage_q[STAGES-1];
  assign rptr_bin   = bin_q;
  assign rptr_delta = delta_q;
  assign rptr_upd   = upd_q;

`ifdef GRAY_PTR_SYNC_CHK_EN
  logic        err_q, err_d;
  logic        viol_s;
  logic [31:0] prev_gray_s;

  // bin_q re-encoded is the previous synchronised Gray value; a set beats a same-edge clear.
  always_comb begin
    prev_gray_s = bin2gray(32'(bin_q), W);
    viol_s      = (popcount(32'(stage_q[STAGES-1]) ^ prev_gray_s, W) > 1);
    if (err_clr) begin
      err_d = viol_s;
    end else begin
      err_d = err_q | viol_s;
    end
  end

  // Sticky error flag.
  always_ff @(posedge wclk) begin
    if (w_rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign gray_err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign gray_err       = 1'b0;
`endif

endmodule

// File: rtl/gray_ptr_sync_mc.sv
// Multi-channel read-to-write Gray pointer synchroniser (top). Optional Gray
// integrity checker enabled by defining GRAY_PTR_SYNC_CHK_EN.
module gray_ptr_sync_mc
  import gray_ptr_sync_pkg::*;
#(
  parameter int PTR_WIDTH = 9,
  parameter int STAGES    = 2,
  parameter int NUM_CH    = 1
) (
  input  logic                 wclk,
  input  logic                 w_rst,
  gray_ptr_sync_mc_if.slave    bus
);

  localparam int W = PTR_WIDTH + 1;

  if ((STAGES < MIN_STAGES) || (STAGES > MAX_STAGES)) begin : g_bad_stages
    $error("gray_ptr_sync_mc: STAGES=%0d outside %0d..%0d", STAGES, MIN_STAGES, MAX_STAGES);
  end
  if ((NUM_CH < MIN_CH) || (NUM_CH > MAX_CH)) begin : g_bad_ch
    $error("gray_ptr_sync_mc: NUM_CH=%0d outside %0d..%0d", NUM_CH, MIN_CH, MAX_CH);
  end

  logic [PTR_WIDTH:0] sync_a  [NUM_CH];
  logic [PTR_WIDTH:0] bin_a   [NUM_CH];
  logic [PTR_WIDTH:0] delta_a [NUM_CH];
  logic               upd_a   [NUM_CH];
  logic               err_a   [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gray_ptr_sync_ch #(
      .PTR_WIDTH (PTR_WIDTH),
      .STAGES    (STAGES)
    ) u_ch (
      .wclk       (wclk),
      .w_rst      (w_rst),
      .rptr_gray  (bus.rptr_gray[c*W +: W]),
      .err_clr    (bus.err_clr),
      .rptr_sync  (sync_a[c]),
      .rptr_bin   (bin_a[c]),
      .rptr_delta (delta_a[c]),
      .rptr_upd   (upd_a[c]),
      .gray_err   (err_a[c])
    );
  end

  // Pack per-channel results onto the bus.
  always_comb begin
    bus.rptr_sync  = '0;
    bus.rptr_bin   = '0;
    bus.rptr_delta = '0;
    bus.rptr_upd   = '0;
    bus.gray_err   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.rptr_sync[c*W +: W]  = sync_a[c];
      bus.rptr_bin[c*W +: W]   = bin_a[c];
      bus.rptr_delta[c*W +: W] = delta_a[c];
      bus.rptr_upd[c]          = upd_a[c];
      bus.gray_err[c]          = err_a[c];
    end
  end

endmodule
